block_lock_ctrl: RTL

- Lock controller sequencing the RX block-sync datapath.
- Takes the per-block best-offset candidate from the header-count search and freezes it as the locked offset once it is stable.
- Verifies the frozen offset over a run of blocks, then monitors header errors to declare or drop block lock.
- Drives a clear strobe that restarts the offset search whenever lock is abandoned.

---
 rtl/block_lock_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/block_lock_ctrl.sv
// Block-lock controller: freezes a stable search offset, verifies it, then tracks header errors.
// Optional BLOCK_LOCK_STATS_EN adds lock-loss and bad-header statistics outputs.
module block_lock_ctrl #(
   parameter int CAND_STABLE = 8,
   parameter int LOCK_CNT    = 32,
   parameter int WINDOW      = 64,
   parameter int UNLOCK_BAD  = 16,
   parameter int MAX_OFFSET  = 64
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       blk_valid_i,
   input  logic [7:0] cand_offset_i,
   input  logic [1:0] hdr_i,
   output logic       search_clr_o,
   output logic [7:0] locked_offset_o,
   output logic       block_lock_o,
   output logic [1:0] state_o
`ifdef BLOCK_LOCK_STATS_EN
   ,
   output logic [15:0] lock_loss_cnt_o,
   output logic [15:0] bad_hdr_cnt_o
`endif
);

   localparam int SW = $clog2(CAND_STABLE + 1);
   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WINDOW + 1);
   localparam int BW = $clog2(UNLOCK_BAD + 1);

   localparam logic [SW-1:0] L_STABLE = SW'(CAND_STABLE);
   localparam logic [GW-1:0] L_LOCK   = GW'(LOCK_CNT);
   localparam logic [WW-1:0] L_WIN    = WW'(WINDOW);
   localparam logic [BW-1:0] L_UNLOCK = BW'(UNLOCK_BAD);
   localparam logic [8:0]    L_MAX    = 9'(MAX_OFFSET);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_HUNT   = 2'd1,
      S_VERIFY = 2'd2,
      S_LOCKED = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic          r_search_clr;
   logic [7:0]    r_offset, w_offset_nxt;
   logic          r_lock, w_lock_nxt;
   logic [SW-1:0] r_stable, w_stable_nxt;
   logic [GW-1:0] r_good, w_good_nxt;
   logic [WW-1:0] r_win, w_win_nxt;
   logic [BW-1:0] r_bad, w_bad_nxt;
   logic          w_hdr_ok;
   logic          w_cand_ok;

   assign w_hdr_ok  = (hdr_i == 2'b01) || (hdr_i == 2'b10);
   assign w_cand_ok = ({1'b0, cand_offset_i} <= L_MAX);

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_lock_nxt   = r_lock;
      w_stable_nxt = r_stable;
      w_good_nxt   = r_good;
      w_win_nxt    = r_win;
      w_bad_nxt    = r_bad;

      case (r_state)
         S_CLEAR: begin
            w_state_nxt  = S_HUNT;
            w_stable_nxt = '0;
            w_good_nxt   = '0;
            w_win_nxt    = '0;
            w_bad_nxt    = '0;
         end
         S_HUNT: begin
            if (blk_valid_i) begin
               if (w_cand_ok && (cand_offset_i == r_offset)) begin
                  w_stable_nxt = (r_stable == L_STABLE) ? r_stable : r_stable + SW'(1);
               end else begin
                  w_offset_nxt = w_cand_ok ? cand_offset_i : 8'd0;
                  w_stable_nxt = w_cand_ok ? SW'(1) : '0;
               end
               if (w_stable_nxt == L_STABLE) begin
                  w_state_nxt = S_VERIFY;
                  w_good_nxt  = '0;
               end
            end
         end
         S_VERIFY: begin
            if (blk_valid_i) begin
               if (w_hdr_ok) begin
                  w_good_nxt = (r_good == L_LOCK) ? r_good : r_good + GW'(1);
                  if (w_good_nxt == L_LOCK) begin
                     w_state_nxt = S_LOCKED;
                     w_lock_nxt  = 1'b1;
                     w_win_nxt   = '0;
                     w_bad_nxt   = '0;
                  end
               end else begin
                  w_state_nxt = S_CLEAR;
               end
            end
         end
         S_LOCKED: begin
            if (blk_valid_i) begin
               w_win_nxt = (r_win == L_WIN) ? r_win : r_win + WW'(1);
               if (!w_hdr_ok) begin
                  w_bad_nxt = (r_bad == L_UNLOCK) ? r_bad : r_bad + BW'(1);
               end
               // Unlock wins over a window rollover landing on the same strobe.
               if (w_bad_nxt == L_UNLOCK) begin
                  w_lock_nxt  = 1'b0;
                  w_state_nxt = S_CLEAR;
               end else if (w_win_nxt == L_WIN) begin
                  w_win_nxt = '0;
                  w_bad_nxt = '0;
               end
            end
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_CLEAR;
         r_search_clr <= 1'b1;
         r_offset     <= 8'd0;
         r_lock       <= 1'b0;
         r_stable     <= '0;
         r_good       <= '0;
         r_win        <= '0;
         r_bad        <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_search_clr <= (w_state_nxt == S_CLEAR);
         r_offset     <= w_offset_nxt;
         r_lock       <= w_lock_nxt;
         r_stable     <= w_stable_nxt;
         r_good       <= w_good_nxt;
         r_win        <= w_win_nxt;
         r_bad        <= w_bad_nxt;
      end
   end

   assign search_clr_o    = r_search_clr;
   assign locked_offset_o = r_offset;
   assign block_lock_o    = r_lock;
   assign state_o         = r_state;

`ifdef BLOCK_LOCK_STATS_EN
   logic [15:0] r_lock_loss, r_bad_hdr;
   logic        w_loss;
   logic        w_bad_locked;

   assign w_loss       = (r_state == S_LOCKED) && (w_state_nxt == S_CLEAR);
   assign w_bad_locked = (r_state == S_LOCKED) && blk_valid_i && !w_hdr_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lock_loss <= 16'd0;
         r_bad_hdr   <= 16'd0;
      end else begin
         if (w_loss && (r_lock_loss != 16'hFFFF)) r_lock_loss <= r_lock_loss + 16'd1;
         if (w_bad_locked && (r_bad_hdr != 16'hFFFF)) r_bad_hdr <= r_bad_hdr + 16'd1;
      end
   end

   assign lock_loss_cnt_o = r_lock_loss;
   assign bad_hdr_cnt_o   = r_bad_hdr;
`endif

endmodule
